kbd_input_ctrl: RTL and testbench



---
 rtl/kbd_input_ctrl.sv | 159 +++++++++++++++
 tb/tb_kbd_input_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_input_ctrl.sv
// PS/2 set-2 scancodes to decimal values for the CPU input port.
// Digits accumulate in ENTRY; Enter hands the value off over control/status.
module kbd_input_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  code_valid,
  input  logic [7:0]            code,
  input  logic                  status,
  output logic                  control,
  output logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] entry,
  output logic                  entering,
  output logic                  ovf
);

  localparam int WW = DATA_WIDTH + 4;
  localparam logic [WW-1:0] MAXW = {4'b0, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HANDOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   in_q, in_d;
  logic                    ovf_q, ovf_d;
  logic                    dig_q, dig_d;
  logic                    brk_q, brk_d;
  logic                    ext_q, ext_d;

  logic                    is_dig;
  logic [3:0]              dval;
  logic [WW-1:0]           acc_w;
  logic [WW-1:0]           wide;
  logic                    sat;
  logic                    eff;

  // Map digit make codes to their decimal value.
  always_comb begin
    is_dig = 1'b1;
    dval   = 4'd0;
    case (code)
      8'h45: dval = 4'd0;
      8'h16: dval = 4'd1;
      8'h1E: dval = 4'd2;
      8'h26: dval = 4'd3;
      8'h25: dval = 4'd4;
      8'h2E: dval = 4'd5;
      8'h36: dval = 4'd6;
      8'h3D: dval = 4'd7;
      8'h3E: dval = 4'd8;
      8'h46: dval = 4'd9;
      default: is_dig = 1'b0;
    endcase
  end

  // acc*10 + digit in the widened domain, flagged when it exceeds max.
  assign acc_w = {4'b0, acc_q};
  assign wide  = (acc_w << 3) + (acc_w << 1) + {{DATA_WIDTH{1'b0}}, dval};
  assign sat   = wide > MAXW;

  // Next-state: prefix tracking, then per-state byte and handshake handling.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    in_d    = in_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    eff     = 1'b0;

    if (code_valid) begin
      if (code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (code == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        eff = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (status) begin
          state_d = ENTRY;
          acc_d   = '0;
          ovf_d   = 1'b0;
          dig_d   = 1'b0;
        end
      end
      ENTRY: begin
        if (!status) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          dig_d   = 1'b0;
        end else if (eff) begin
          if (is_dig) begin
            acc_d = sat ? {DATA_WIDTH{1'b1}} : wide[DATA_WIDTH-1:0];
            ovf_d = ovf_q | sat;
            dig_d = 1'b1;
          end else if (code == 8'h66) begin
            acc_d = '0;
            ovf_d = 1'b0;
            dig_d = 1'b0;
          end else if (code == 8'h5A && dig_q) begin
            in_d    = acc_q;
            state_d = HANDOFF;
          end
        end
      end
      HANDOFF: begin
        if (!status) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          dig_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      in_q    <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
    end
  end

  assign control  = (state_q == HANDOFF);
  assign entering = (state_q == ENTRY);
  assign in       = in_q;
  assign entry    = acc_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_kbd_input_ctrl.sv
// Bench for kbd_input_ctrl: directed table, reset corner,
// and random bytes against a behavioural model.
module tb_kbd_input_ctrl;

  localparam int DW   = 16;
  localparam int MAXV = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          code_valid = 1'b0;
  logic [7:0]    code = 8'h00;
  logic          status = 1'b0;
  logic          control;
  logic [DW-1:0] in_v;
  logic [DW-1:0] entry;
  logic          entering;
  logic          ovf;

  always #5 clk = ~clk;

  kbd_input_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .status     (status),
    .control    (control),
    .in         (in_v),
    .entry      (entry),
    .entering   (entering),
    .ovf        (ovf)
  );

  int vecs = 0;
  int errs = 0;

  // Behavioural model: 0=idle, 1=entering digits, 2=value handed off.
  int m_phase;
  int m_acc;
  int m_in;
  int m_ndig;
  bit m_ovf;
  bit m_brk;
  bit m_ext;

  function automatic int digit_of(input logic [7:0] c);
    case (c)
      8'h45: return 0;
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h25: return 4;
      8'h2E: return 5;
      8'h36: return 6;
      8'h3D: return 7;
      8'h3E: return 8;
      8'h46: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic m_clear();
    m_acc  = 0;
    m_ovf  = 0;
    m_ndig = 0;
  endtask

  task automatic m_reset();
    m_phase = 0;
    m_in    = 0;
    m_brk   = 0;
    m_ext   = 0;
    m_clear();
  endtask

  task automatic model_step(input bit st, input bit cv, input logic [7:0] c);
    bit eff;
    int d;
    eff = 0;
    if (cv) begin
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else if (m_brk || m_ext) begin
        m_brk = 0;
        m_ext = 0;
      end else eff = 1;
    end
    d = digit_of(c);
    case (m_phase)
      0: if (st) begin
        m_phase = 1;
        m_clear();
      end
      1: if (!st) begin
        m_phase = 0;
        m_clear();
      end else if (eff) begin
        if (d >= 0) begin
          m_acc = m_acc * 10 + d;
          if (m_acc > MAXV) begin
            m_acc = MAXV;
            m_ovf = 1;
          end
          m_ndig++;
        end else if (c == 8'h66) begin
          m_clear();
        end else if (c == 8'h5A && m_ndig > 0) begin
          m_in    = m_acc;
          m_phase = 2;
        end
      end
      2: if (!st) begin
        m_phase = 0;
        m_clear();
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_exp(input string tag, input bit e_ctrl, input int e_in,
                           input int e_entry, input bit e_ent, input bit e_ovf);
    vecs++;
    if (control !== e_ctrl || in_v !== DW'(e_in) || entry !== DW'(e_entry) ||
        entering !== e_ent || ovf !== e_ovf) begin
      errs++;
      $display("FAIL %s: got ctrl=%0b in=%0d entry=%0d entering=%0b ovf=%0b, want ctrl=%0b in=%0d entry=%0d entering=%0b ovf=%0b",
               tag, control, in_v, entry, entering, ovf,
               e_ctrl, e_in, e_entry, e_ent, e_ovf);
    end
  endtask

  task automatic check_model(input string tag);
    check_exp(tag, m_phase == 2, m_in, m_acc, m_phase == 1, m_ovf);
  endtask

  task automatic step(input bit st, input bit cv, input logic [7:0] c);
    status     = st;
    code_valid = cv;
    code       = c;
    @(posedge clk);
    model_step(st, cv, c);
    #1;
    code_valid = 1'b0;
  endtask

  typedef struct {
    bit         st;
    bit         cv;
    logic [7:0] c;
    bit         e_ctrl;
    int         e_in;
    int         e_entry;
    bit         e_ent;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit st, input bit cv, input logic [7:0] c,
                              input bit ec, input int ei, input int ee,
                              input bit en, input bit eo);
    vec_t v;
    v.st = st; v.cv = cv; v.c = c;
    v.e_ctrl = ec; v.e_in = ei; v.e_entry = ee; v.e_ent = en; v.e_ovf = eo;
    tbl.push_back(v);
  endfunction

  logic [7:0] pool [14] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E, 8'h46, 8'h5A, 8'h66, 8'hF0, 8'hE0};

  initial begin
    // 123 with break codes interleaved, then handoff and release
    add(1,0,8'h00, 0,  0,  0,1,0);
    add(1,1,8'h16, 0,  0,  1,1,0);
    add(1,1,8'hF0, 0,  0,  1,1,0);
    add(1,1,8'h16, 0,  0,  1,1,0);
    add(1,1,8'h1E, 0,  0, 12,1,0);
    add(1,1,8'hF0, 0,  0, 12,1,0);
    add(1,1,8'h1E, 0,  0, 12,1,0);
    add(1,1,8'h26, 0,  0,123,1,0);
    add(1,1,8'hF0, 0,  0,123,1,0);
    add(1,1,8'h26, 0,  0,123,1,0);
    add(1,1,8'h5A, 1,123,123,0,0);
    add(1,1,8'hF0, 1,123,123,0,0);
    add(1,1,8'h5A, 1,123,123,0,0);
    add(0,0,8'h00, 0,123,  0,0,0);
    // saturation with six nines
    add(1,0,8'h00, 0,123,    0,1,0);
    add(1,1,8'h46, 0,123,    9,1,0);
    add(1,1,8'h46, 0,123,   99,1,0);
    add(1,1,8'h46, 0,123,  999,1,0);
    add(1,1,8'h46, 0,123, 9999,1,0);
    add(1,1,8'h46, 0,123,65535,1,1);
    add(1,1,8'h46, 0,123,65535,1,1);
    add(1,1,8'h5A, 1,65535,65535,0,1);
    add(0,0,8'h00, 0,65535,    0,0,0);
    // backspace and Enter with no digits
    add(1,0,8'h00, 0,65535,0,1,0);
    add(1,1,8'h1E, 0,65535,2,1,0);
    add(1,1,8'h66, 0,65535,0,1,0);
    add(1,1,8'h5A, 0,65535,0,1,0);
    add(1,1,8'h36, 0,65535,6,1,0);
    add(1,1,8'h5A, 1,6,6,0,0);
    add(0,0,8'h00, 0,6,0,0,0);
    // idle discards, extended codes ignored, digit 0 commits
    add(0,1,8'h16, 0,6,0,0,0);
    add(0,1,8'h5A, 0,6,0,0,0);
    add(1,0,8'h00, 0,6,0,1,0);
    add(1,1,8'hE0, 0,6,0,1,0);
    add(1,1,8'hF0, 0,6,0,1,0);
    add(1,1,8'h16, 0,6,0,1,0);
    add(1,1,8'hE0, 0,6,0,1,0);
    add(1,1,8'h5A, 0,6,0,1,0);
    add(1,1,8'h45, 0,6,0,1,0);
    add(1,1,8'h5A, 1,0,0,0,0);
    // handoff ignores bytes; one-cycle status low re-enters
    add(1,1,8'h16, 1,0,0,0,0);
    add(1,1,8'h5A, 1,0,0,0,0);
    add(0,0,8'h00, 0,0,0,0,0);
    add(1,0,8'h00, 0,0,0,1,0);
    add(1,1,8'h1E, 0,0,2,1,0);
    add(1,1,8'h5A, 1,2,2,0,0);

    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_exp("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].cv, tbl[i].c);
      check_exp($sformatf("tbl%0d", i), tbl[i].e_ctrl, tbl[i].e_in,
                tbl[i].e_entry, tbl[i].e_ent, tbl[i].e_ovf);
      check_model($sformatf("tblmodel%0d", i));
    end

    // asynchronous reset while control is high
    #3;
    rst_n = 1'b0;
    #1;
    check_exp("async_rst", 0, 0, 0, 0, 0);
    m_reset();
    status = 1'b1;
    @(posedge clk);
    #1;
    check_exp("in_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h00);
    check_exp("post_rst_entry", 0, 0, 0, 1, 0);

    // random bytes; status only moves on cycles without a byte
    for (int n = 0; n < 3000; n++) begin
      bit         cv;
      bit         st;
      logic [7:0] c;
      int         k;
      cv = 1'($urandom_range(0, 1));
      st = status;
      if (!cv && $urandom_range(0, 15) == 0) st = ~st;
      k = $urandom_range(0, 15);
      c = (k < 14) ? pool[k] : 8'($urandom);
      step(st, cv, c);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
